dsp_job_ctrl: RTL and testbench

Job sequencer in front of the shared FIR/IIR/FFT datapath (`dsp_top`). It accepts one job descriptor at a time and, for each job:
- programs `mode`;
- optionally loads FIR or IIR coefficients from a coefficient stream;
- gates the sample stream into the datapath, framing FFT blocks with `start`/`done`;
- counts results and reports completion or timeout.

`mode` never changes while samples or results are in flight.

---
 rtl/dsp_job_ctrl_if.sv | 55 +++++
 rtl/dsp_job_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dsp_job_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_job_ctrl_if.sv
// Bundle of every handshake and bus signal between the job sequencer, its
// job/coefficient/sample sources and the shared FIR/IIR/FFT datapath.
interface dsp_job_ctrl_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int MAX_TAPS     = 8,
    parameter int IIR_SECTIONS = 2,
    parameter int LEN_WIDTH    = 16
);
    localparam int TAP_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int SEC_W = (IIR_SECTIONS > 1) ? $clog2(IIR_SECTIONS) : 1;

    logic                  job_valid, job_ready, job_load_coef;
    logic [1:0]            job_mode;
    logic [LEN_WIDTH-1:0]  job_len;
    logic                  coef_valid, coef_ready;
    logic [COEF_WIDTH-1:0] coef_data;
    logic                  src_valid, src_ready;
    logic [DATA_WIDTH-1:0] src_real, src_imag;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] din_real, din_imag;
    logic                  din_valid, din_ready, dout_valid;
    logic                  fir_coeff_wr_en;
    logic [TAP_W-1:0]      fir_coeff_index;
    logic [COEF_WIDTH-1:0] fir_coeff_value;
    logic                  iir_coeff_wr_en;
    logic [SEC_W-1:0]      iir_section_index;
    logic [2:0]            iir_coeff_sel;
    logic [COEF_WIDTH-1:0] iir_coeff_value;
    logic                  fft_start, fft_done, busy, job_done, job_err;

    // Sequencer side
    modport slave (
        input  job_valid, job_mode, job_len, job_load_coef,
        input  coef_valid, coef_data, src_valid, src_real, src_imag,
        input  din_ready, dout_valid, fft_done,
        output job_ready, coef_ready, src_ready, mode,
        output din_real, din_imag, din_valid,
        output fir_coeff_wr_en, fir_coeff_index, fir_coeff_value,
        output iir_coeff_wr_en, iir_section_index, iir_coeff_sel, iir_coeff_value,
        output fft_start, busy, job_done, job_err
    );

    // Environment side (job source, sample source, datapath)
    modport master (
        output job_valid, job_mode, job_len, job_load_coef,
        output coef_valid, coef_data, src_valid, src_real, src_imag,
        output din_ready, dout_valid, fft_done,
        input  job_ready, coef_ready, src_ready, mode,
        input  din_real, din_imag, din_valid,
        input  fir_coeff_wr_en, fir_coeff_index, fir_coeff_value,
        input  iir_coeff_wr_en, iir_section_index, iir_coeff_sel, iir_coeff_value,
        input  fft_start, busy, job_done, job_err
    );
endinterface

// File: rtl/dsp_job_ctrl.sv
// Job sequencer for the shared FIR/IIR/FFT datapath: accepts one descriptor,
// programs mode, optionally loads coefficients, gates samples (framing FFT
// blocks), counts results and reports completion or drain timeout.
module dsp_job_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int COEF_WIDTH    = 16,
    parameter int MAX_TAPS      = 8,
    parameter int IIR_SECTIONS  = 2,
    parameter int FFT_N         = 8,
    parameter int LEN_WIDTH     = 16,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dsp_job_ctrl_if.slave    io_bus
);
    localparam int TAP_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int SEC_W = (IIR_SECTIONS > 1) ? $clog2(IIR_SECTIONS) : 1;
    localparam int FRM_W = (FFT_N > 1) ? $clog2(FFT_N) : 1;
    localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [1:0] M_FIR = 2'd0, M_IIR = 2'd1, M_FFT = 2'd2, M_BAD = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FSTART, S_STREAM, S_FWAIT, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_mode, r_jmode;
    logic [LEN_WIDTH-1:0]  r_len, r_in_cnt, r_out_cnt;
    logic [FRM_W-1:0]      r_frm_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_err;
    logic [TAP_W-1:0]      r_tap;
    logic [SEC_W-1:0]      r_sec;
    logic [2:0]            r_sel;
    logic                  r_fir_wr, r_iir_wr;
    logic [TAP_W-1:0]      r_fir_idx;
    logic [SEC_W-1:0]      r_iir_sec;
    logic [2:0]            r_iir_sel;
    logic [COEF_WIDTH-1:0] r_fir_val, r_iir_val;

    logic                  w_reject, w_coef_hs, w_coef_last, w_gate, w_in_hs, w_in_last;
    logic                  w_frm_last, w_out_en, w_out_done, w_timeout;
    logic [LEN_WIDTH-1:0]  w_out_nxt;

    // A job is illegal if its mode is reserved, it is empty, or an FFT job
    // would leave a partial frame.
    assign w_reject    = (io_bus.job_mode == M_BAD) || (io_bus.job_len == '0) ||
                         ((io_bus.job_mode == M_FFT) && ((io_bus.job_len % LEN_WIDTH'(FFT_N)) != '0));
    assign w_coef_hs   = (r_state == S_LOAD) && io_bus.coef_valid;
    assign w_coef_last = (r_jmode == M_FIR) ? (r_tap == TAP_W'(MAX_TAPS - 1))
                                            : ((r_sec == SEC_W'(IIR_SECTIONS - 1)) && (r_sel == 3'd4));
    assign w_gate      = (r_in_cnt == r_len);
    assign w_in_hs     = (r_state == S_STREAM) && !w_gate && io_bus.src_valid && io_bus.din_ready;
    assign w_in_last   = ((r_in_cnt + 1'b1) == r_len);
    assign w_frm_last  = (r_frm_cnt == FRM_W'(FFT_N - 1));
    // Results only belong to the job while its samples can be in the datapath.
    assign w_out_en    = io_bus.dout_valid && ((r_state == S_STREAM) || (r_state == S_FSTART) ||
                                               (r_state == S_FWAIT)  || (r_state == S_DRAIN));
    assign w_out_nxt   = r_out_cnt + {{(LEN_WIDTH-1){1'b0}}, w_out_en};
    assign w_out_done  = (w_out_nxt == r_len);
    // r_to_cnt holds the number of cycles since the last result, so expiry
    // lands the done pulse exactly DRAIN_TIMEOUT cycles after that result.
    assign w_timeout   = (r_state == S_DRAIN) && !io_bus.dout_valid &&
                         (r_to_cnt == TO_W'(DRAIN_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (io_bus.job_valid) begin
                if (w_reject)                                              w_next = S_DONE;
                else if (io_bus.job_load_coef && (io_bus.job_mode != M_FFT)) w_next = S_LOAD;
                else if (io_bus.job_mode == M_FFT)                         w_next = S_FSTART;
                else                                                       w_next = S_STREAM;
            end
            S_LOAD:   if (w_coef_hs && w_coef_last) w_next = S_STREAM;
            S_FSTART: w_next = S_STREAM;
            S_STREAM: if (w_in_hs) begin
                if ((r_jmode == M_FFT) && w_frm_last) w_next = S_FWAIT;
                else if (w_in_last)                   w_next = S_DRAIN;
            end
            S_FWAIT:  if (io_bus.fft_done) w_next = w_gate ? S_DRAIN : S_FSTART;
            S_DRAIN:  if (w_out_done || w_timeout) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; samples pass straight through while streaming
    always_comb begin
        io_bus.job_ready  = (r_state == S_IDLE);
        io_bus.coef_ready = (r_state == S_LOAD);
        io_bus.src_ready  = 1'b0;
        io_bus.din_valid  = 1'b0;
        io_bus.din_real   = {DATA_WIDTH{1'b0}};
        io_bus.din_imag   = {DATA_WIDTH{1'b0}};
        io_bus.fft_start  = (r_state == S_FSTART);
        io_bus.busy       = (r_state != S_IDLE);
        io_bus.job_done   = (r_state == S_DONE);
        io_bus.job_err    = (r_state == S_DONE) && r_err;
        if ((r_state == S_STREAM) && !w_gate) begin
            io_bus.src_ready = io_bus.din_ready;
            io_bus.din_valid = io_bus.src_valid;
            io_bus.din_real  = io_bus.src_real;
            io_bus.din_imag  = io_bus.src_imag;
        end
    end

    // Job latch, sample/result/frame/coefficient counters and error flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode <= '0; r_jmode <= '0; r_len <= '0; r_err <= 1'b0;
            r_in_cnt <= '0; r_out_cnt <= '0; r_frm_cnt <= '0; r_to_cnt <= '0;
            r_tap <= '0; r_sec <= '0; r_sel <= '0;
        end else begin
            if (w_coef_hs) begin
                if (r_jmode == M_FIR) r_tap <= r_tap + 1'b1;
                else if (r_sel == 3'd4) begin r_sel <= '0; r_sec <= r_sec + 1'b1; end
                else r_sel <= r_sel + 1'b1;
            end
            if (w_in_hs) begin
                r_in_cnt  <= r_in_cnt + 1'b1;
                r_frm_cnt <= w_frm_last ? '0 : r_frm_cnt + 1'b1;
            end
            r_out_cnt <= w_out_nxt;
            r_to_cnt  <= ((r_state == S_DRAIN) && !io_bus.dout_valid) ? r_to_cnt + 1'b1 : TO_W'(1);
            if (w_timeout && !w_out_done) r_err <= 1'b1;
            if ((r_state == S_IDLE) && io_bus.job_valid) begin
                r_jmode <= io_bus.job_mode;
                r_len   <= io_bus.job_len;
                r_err   <= w_reject;
                if (!w_reject) r_mode <= io_bus.job_mode;
                r_in_cnt <= '0; r_out_cnt <= '0; r_frm_cnt <= '0;
                r_tap <= '0; r_sec <= '0; r_sel <= '0;
            end
        end
    end

    // Coefficient write port: one registered write per accepted coefficient
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fir_wr <= 1'b0; r_iir_wr <= 1'b0;
            r_fir_idx <= '0; r_fir_val <= '0;
            r_iir_sec <= '0; r_iir_sel <= '0; r_iir_val <= '0;
        end else begin
            r_fir_wr <= w_coef_hs && (r_jmode == M_FIR);
            r_iir_wr <= w_coef_hs && (r_jmode == M_IIR);
            if (w_coef_hs && (r_jmode == M_FIR)) begin
                r_fir_idx <= r_tap;
                r_fir_val <= io_bus.coef_data;
            end
            if (w_coef_hs && (r_jmode == M_IIR)) begin
                r_iir_sec <= r_sec;
                r_iir_sel <= r_sel;
                r_iir_val <= io_bus.coef_data;
            end
        end
    end

    assign io_bus.mode              = r_mode;
    assign io_bus.fir_coeff_wr_en   = r_fir_wr;
    assign io_bus.fir_coeff_index   = r_fir_idx;
    assign io_bus.fir_coeff_value   = r_fir_val;
    assign io_bus.iir_coeff_wr_en   = r_iir_wr;
    assign io_bus.iir_section_index = r_iir_sec;
    assign io_bus.iir_coeff_sel     = r_iir_sel;
    assign io_bus.iir_coeff_value   = r_iir_val;
endmodule

// File: tb/tb_dsp_job_ctrl.sv
// Directed bench for dsp_job_ctrl: echoing 2-cycle datapath model, event
// monitors, and hand-computed expectations for each job scenario.
module tb_dsp_job_ctrl;
    localparam int TMO = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp_job_ctrl_if bus();
    dsp_job_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_in = 0, n_dv = 0, n_fst = 0, n_done = 0, n_coef = 0, n_fir = 0, n_iir = 0;
    int last_dv_cyc = 0, done_cyc = 0, fst_cyc = 0, fst_in_cyc = 0;
    bit fst_pend = 1'b0;
    int res_quota = 1 << 30;
    logic [1:0]  dv_pipe = 2'b00;
    logic [31:0] fir_log[32];
    logic [31:0] iir_log[32];
    int          fir_cyc[32];
    int          coef_cyc[32];

    // Datapath echo (2-cycle latency) with a result budget for the timeout case
    assign bus.dout_valid = dv_pipe[1] && (n_dv < res_quota);
    assign bus.src_real   = 16'(n_in + 32'h100);
    assign bus.src_imag   = ~bus.src_real;

    // Event monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        dv_pipe <= {dv_pipe[0], bus.din_valid && bus.din_ready};
        if (bus.fir_coeff_wr_en) begin
            fir_log[n_fir % 32] <= {16'(bus.fir_coeff_index), bus.fir_coeff_value};
            fir_cyc[n_fir % 32] <= cyc;
            n_fir <= n_fir + 1;
        end
        if (bus.iir_coeff_wr_en) begin
            iir_log[n_iir % 32] <= {8'(bus.iir_section_index), 8'(bus.iir_coeff_sel), bus.iir_coeff_value};
            n_iir <= n_iir + 1;
        end
        if (bus.coef_valid && bus.coef_ready) begin
            coef_cyc[n_coef % 32] <= cyc;
            n_coef <= n_coef + 1;
        end
        if (bus.din_valid && bus.din_ready) n_in <= n_in + 1;
        if (bus.dout_valid) begin n_dv <= n_dv + 1; last_dv_cyc <= cyc; end
        if (bus.fft_start) begin
            n_fst <= n_fst + 1; fst_cyc <= cyc; fst_pend <= 1'b1;
        end else if (fst_pend && bus.din_valid && bus.din_ready) begin
            fst_pend <= 1'b0; fst_in_cyc <= cyc;
        end
        if (bus.job_done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic submit(input logic [1:0] m, input int len, input logic ld);
        @(negedge clk);
        bus.job_valid = 1'b1; bus.job_mode = m; bus.job_len = 16'(len); bus.job_load_coef = ld;
        chk("job_ready_idle", 32'(bus.job_ready), 1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("job_ready_low", 32'(bus.job_ready), 0);
    endtask

    task automatic send_coefs(input int n, input bit toggle);
        int i = 0;
        int g = 0;
        while (i < n && g < 100) begin
            @(negedge clk);
            g++;
            if (toggle && (g % 2 == 0)) bus.coef_valid = 1'b0;
            else begin
                bus.coef_valid = 1'b1;
                bus.coef_data  = 16'(i + 1);
                if (bus.coef_ready) i++;
            end
        end
        @(negedge clk);
        bus.coef_valid = 1'b0;
        chk("coef_sent", i, n);
    endtask

    task automatic wait_done(input int max_cyc, input string tag, output logic err);
        int n = 0;
        while (!bus.job_done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(bus.job_done), 1);
        err = bus.job_err;
        @(negedge clk);
    endtask

    initial begin
        logic e;
        int b_in, b_dv, b_fst, b_fir, b_iir, b_coef, b_done, g;
        logic [1:0] rej_m[3];
        int         rej_l[3];
        rej_m = '{2'd3, 2'd0, 2'd2};
        rej_l = '{4, 0, 12};

        bus.job_valid = 0; bus.job_mode = 0; bus.job_len = 0; bus.job_load_coef = 0;
        bus.coef_valid = 0; bus.coef_data = 0; bus.src_valid = 0;
        bus.din_ready = 1; bus.fft_done = 0;
        repeat (3) @(negedge clk);
        // {busy, job_ready, src_ready, din_valid, job_done, job_err, fft_start, coef_ready, fir_wr, iir_wr}
        chk("rst_ctl", {bus.busy, bus.job_ready, bus.src_ready, bus.din_valid, bus.job_done,
                        bus.job_err, bus.fft_start, bus.coef_ready, bus.fir_coeff_wr_en,
                        bus.iir_coeff_wr_en}, 32'b0100000000);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_idx_val", {16'(bus.fir_coeff_index), bus.fir_coeff_value}, 0);
        rst_n = 1'b1;

        // FIR load + stream
        bus.src_valid = 1'b1;
        b_in = n_in; b_dv = n_dv; b_fir = n_fir; b_coef = n_coef;
        submit(2'd0, 4, 1'b1);
        send_coefs(8, 1'b0);
        chk("fir_no_in_during_load", n_in - b_in, 0);
        wait_done(100, "fir", e);
        chk("fir_err", 32'(e), 0);
        chk("fir_nwr", n_fir - b_fir, 8);
        for (int k = 0; k < 8; k++)
            chk("fir_wr", fir_log[(b_fir + k) % 32], {16'(k), 16'(k + 1)});
        chk("fir_b2b", fir_cyc[(b_fir + 7) % 32] - fir_cyc[b_fir % 32], 7);
        chk("fir_wr_lat", fir_cyc[b_fir % 32] - coef_cyc[b_coef % 32], 1);
        chk("fir_nin", n_in - b_in, 4);
        chk("fir_nout", n_dv - b_dv, 4);
        chk("fir_done_lat", done_cyc - last_dv_cyc, 1);
        chk("fir_mode", 32'(bus.mode), 0);

        // IIR load with gappy coefficient stream
        b_fir = n_fir; b_iir = n_iir; b_in = n_in;
        submit(2'd1, 2, 1'b1);
        send_coefs(10, 1'b1);
        wait_done(100, "iir", e);
        chk("iir_err", 32'(e), 0);
        chk("iir_nwr", n_iir - b_iir, 10);
        chk("iir_no_fir", n_fir - b_fir, 0);
        for (int k = 0; k < 10; k++)
            chk("iir_wr", iir_log[(b_iir + k) % 32], {8'(k / 5), 8'(k % 5), 16'(k + 1)});
        chk("iir_nin", n_in - b_in, 2);
        chk("iir_mode", 32'(bus.mode), 1);

        // FFT framing, 2 frames of 8
        b_in = n_in; b_dv = n_dv; b_fst = n_fst;
        submit(2'd2, 16, 1'b1);
        for (int f = 0; f < 2; f++) begin
            int viol = 0;
            g = 0;
            while ((n_in - b_in) < 8 * (f + 1) && g < 100) begin
                @(negedge clk);
                g++;
            end
            for (int w = 0; w < 4; w++) begin
                if (w > 0) @(negedge clk);
                if (bus.src_ready !== 1'b0) viol++;
            end
            chk("fft_fwait_src_ready", viol, 0);
            chk("fft_frame_in", n_in - b_in, 8 * (f + 1));
            bus.fft_done = 1'b1;
            @(negedge clk);
            bus.fft_done = 1'b0;
        end
        wait_done(50, "fft", e);
        chk("fft_err", 32'(e), 0);
        chk("fft_nstart", n_fst - b_fst, 2);
        chk("fft_start_lead", fst_in_cyc - fst_cyc, 1);
        chk("fft_nin", n_in - b_in, 16);
        chk("fft_nout", n_dv - b_dv, 16);
        chk("fft_mode", 32'(bus.mode), 2);

        // Rejects: reserved mode, zero length, FFT partial frame
        for (int r = 0; r < 3; r++) begin
            b_in = n_in; b_fst = n_fst; b_fir = n_fir;
            submit(rej_m[r], rej_l[r], 1'b1);
            wait_done(3, "rej", e);
            chk("rej_err", 32'(e), 1);
            chk("rej_mode", 32'(bus.mode), 2);
            chk("rej_nin", n_in - b_in, 0);
            chk("rej_nstart", n_fst - b_fst, 0);
            chk("rej_nwr", n_fir - b_fir, 0);
        end

        // Drain timeout: only 3 of 4 results come back
        b_in = n_in; b_dv = n_dv;
        res_quota = n_dv + 3;
        submit(2'd0, 4, 1'b0);
        wait_done(400, "tmo", e);
        chk("tmo_err", 32'(e), 1);
        chk("tmo_lat", done_cyc - last_dv_cyc, TMO);
        chk("tmo_nout", n_dv - b_dv, 3);
        chk("tmo_nin", n_in - b_in, 4);
        res_quota = 1 << 30;

        // Reset in the middle of an IIR stream
        b_in = n_in;
        submit(2'd1, 20, 1'b0);
        g = 0;
        while ((n_in - b_in) < 3 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("mid_din_valid", 32'(bus.din_valid), 1);
        chk("mid_din_real", 32'(bus.din_real), 32'(16'(n_in + 32'h100)));
        chk("mid_mode", 32'(bus.mode), 1);
        b_done = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ctl", {bus.busy, bus.job_ready, bus.src_ready, bus.din_valid, bus.job_done,
                         bus.job_err, bus.fft_start, bus.coef_ready}, 32'b01000000);
        chk("mrst_mode", 32'(bus.mode), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mrst_no_done", n_done - b_done, 0);

        // Recovery job after reset
        b_in = n_in; b_dv = n_dv;
        submit(2'd0, 2, 1'b0);
        wait_done(50, "post", e);
        chk("post_err", 32'(e), 0);
        chk("post_nin", n_in - b_in, 2);
        chk("post_nout", n_dv - b_dv, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
